// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hold/flush controller with divider sequencing and stall counter
module hazard_ctrl_unit #(
   parameter int unsigned DIV_LATENCY = 34,
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_div_i,
   input  logic                  ex_redirect_i,
   input  logic                  mem_req_i,
   input  logic                  mem_ready_i,
   output logic                  pc_hold_o,
   output logic                  if_id_hold_o,
   output logic                  id_ex_hold_o,
   output logic                  ex_mem_hold_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_flush_o,
   output logic                  ex_mem_flush_o,
   output logic                  mem_wb_flush_o,
   output logic                  div_start_o,
   output logic                  div_done_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } state_e;

   localparam logic [7:0] CNT_LOAD = 8'(DIV_LATENCY - 2);

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic               freeze;
   logic               lu;

   assign freeze = mem_req_i & ~mem_ready_i;
   assign lu     = ex_mem_read_i & (ex_rd_addr_i != '0) &
                   ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                    (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

   // The transition out of DIV_BUSY fires on the cycle whose decrement reaches zero,
   // so done lands exactly DIV_LATENCY-1 cycles after the start pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (ex_div_i && !freeze) begin
               cnt_d   = CNT_LOAD;
               state_d = (CNT_LOAD == 8'd0) ? DIV_DONE : DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (!freeze) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pc_hold_o      = 1'b0;
      if_id_hold_o   = 1'b0;
      id_ex_hold_o   = 1'b0;
      ex_mem_hold_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      mem_wb_flush_o = 1'b0;
      div_start_o    = 1'b0;
      div_done_o     = (state_q == DIV_DONE);
      if (freeze) begin
         pc_hold_o      = 1'b1;
         if_id_hold_o   = 1'b1;
         id_ex_hold_o   = 1'b1;
         ex_mem_hold_o  = 1'b1;
         mem_wb_flush_o = 1'b1;
      end else if (state_q == DIV_BUSY) begin
         pc_hold_o      = 1'b1;
         if_id_hold_o   = 1'b1;
         id_ex_hold_o   = 1'b1;
         ex_mem_flush_o = 1'b1;
      end else if (state_q == RUN && ex_div_i) begin
         div_start_o    = 1'b1;
         pc_hold_o      = 1'b1;
         if_id_hold_o   = 1'b1;
         id_ex_hold_o   = 1'b1;
         ex_mem_flush_o = 1'b1;
      end else if (ex_redirect_i) begin
         // ID holds a wrong-path instruction, so a redirect wins over load-use.
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
      end else if (lu) begin
         pc_hold_o      = 1'b1;
         if_id_hold_o   = 1'b1;
         id_ex_flush_o  = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (pc_hold_o && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 8'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
   localparam int L = 34;
   localparam longint STALL_MAX = 64'hFFFF_FFFF;
   // bit order: pc_hold if_id_hold id_ex_hold ex_mem_hold if_id_flush id_ex_flush ex_mem_flush mem_wb_flush div_start div_done
   localparam logic [9:0] P_IDLE     = 10'b00_0000_0000;
   localparam logic [9:0] P_LU       = 10'b11_0001_0000;
   localparam logic [9:0] P_REDIR    = 10'b00_0011_0000;
   localparam logic [9:0] P_START    = 10'b11_1000_1010;
   localparam logic [9:0] P_BUSY     = 10'b11_1000_1000;
   localparam logic [9:0] P_DONE     = 10'b00_0000_0001;
   localparam logic [9:0] P_FRZ      = 10'b11_1100_0100;
   localparam logic [9:0] P_FRZ_DONE = 10'b11_1100_0101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1, rs2, ex_rd;
   logic       rs1_used, rs2_used, ex_mem_read, ex_div, redirect, mem_req, mem_ready;

   logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, div_start, div_done;
   logic [31:0] stall_cnt;
   logic        s_pc_hold, s_if_id_hold, s_id_ex_hold, s_ex_mem_hold;
   logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush, s_div_start, s_div_done;
   logic [3:0]  s_stall_cnt;
   logic [9:0]  obs;

   int     errors = 0;
   int     checks = 0;
   bit     m_div_active;
   int     m_age;
   longint m_stall;

   always #5 clk = ~clk;

   assign obs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush,
                 id_ex_flush, ex_mem_flush, mem_wb_flush, div_start, div_done};

   hazard_ctrl_unit #(.DIV_LATENCY(L), .REG_ADDR_W(5), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
      .ex_rd_addr_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_div_i(ex_div),
      .ex_redirect_i(redirect), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold), .id_ex_hold_o(id_ex_hold),
      .ex_mem_hold_o(ex_mem_hold), .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
      .ex_mem_flush_o(ex_mem_flush), .mem_wb_flush_o(mem_wb_flush),
      .div_start_o(div_start), .div_done_o(div_done), .stall_cnt_o(stall_cnt)
   );

   hazard_ctrl_unit #(.DIV_LATENCY(2), .REG_ADDR_W(5), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
      .ex_rd_addr_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_div_i(ex_div),
      .ex_redirect_i(redirect), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .pc_hold_o(s_pc_hold), .if_id_hold_o(s_if_id_hold), .id_ex_hold_o(s_id_ex_hold),
      .ex_mem_hold_o(s_ex_mem_hold), .if_id_flush_o(s_if_id_flush), .id_ex_flush_o(s_id_ex_flush),
      .ex_mem_flush_o(s_ex_mem_flush), .mem_wb_flush_o(s_mem_wb_flush),
      .div_start_o(s_div_start), .div_done_o(s_div_done), .stall_cnt_o(s_stall_cnt)
   );

   // Reference: a divide is tracked by its age in cycles since the start pulse.
   function automatic logic [9:0] model_out();
      logic fz, lu, busy, done;
      logic [9:0] e;
      fz   = mem_req && !mem_ready;
      lu   = ex_mem_read && (ex_rd != 5'd0) &&
             ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));
      busy = m_div_active && (m_age < L - 1);
      done = m_div_active && (m_age >= L - 1);
      e    = P_IDLE;
      e[0] = done;
      if (fz) begin
         e[9:6] = 4'hF; e[2] = 1'b1;
      end else if (busy) begin
         e[9:7] = 3'b111; e[3] = 1'b1;
      end else if (!done && ex_div) begin
         e[9:7] = 3'b111; e[3] = 1'b1; e[1] = 1'b1;
      end else if (redirect) begin
         e[5] = 1'b1; e[4] = 1'b1;
      end else if (lu) begin
         e[9] = 1'b1; e[8] = 1'b1; e[4] = 1'b1;
      end
      return e;
   endfunction

   task automatic model_reset();
      m_div_active = 1'b0;
      m_age        = 0;
      m_stall      = 0;
   endtask

   task automatic model_advance();
      logic [9:0] e;
      e = model_out();
      if (e[9] && m_stall < STALL_MAX) m_stall++;
      if (m_div_active) begin
         if (m_age >= L - 1 && !(mem_req && !mem_ready)) m_div_active = 1'b0;
         else m_age++;
      end else if (e[1]) begin
         m_div_active = 1'b1;
         m_age        = 1;
      end
   endtask

   task automatic next_cycle();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
      rs1_used = 1'b0; rs2_used = 1'b0; ex_mem_read = 1'b0;
      ex_div = 1'b0; redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_idle();
      model_reset();
      #3;
      checks++;
      if (obs !== P_IDLE) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, P_IDLE); end
      checks++;
      if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (obs !== P_IDLE || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL post_reset_idle: got %b/%0d expected %b/0", obs, stall_cnt, P_IDLE);
         end
         next_cycle();
      end
   endtask

   task automatic test_load_use();
      longint base;
      base = m_stall;
      set_idle();
      ex_mem_read = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1; rs2 = 5'd1; rs2_used = 1'b1;
      #1;
      checks++;
      if (obs !== P_LU) begin errors++; $display("FAIL load_use_rs1: got %b expected %b", obs, P_LU); end
      next_cycle();
      set_idle();
      #1;
      checks++;
      if (obs !== P_IDLE) begin errors++; $display("FAIL load_use_release: got %b expected %b", obs, P_IDLE); end
      checks++;
      if (stall_cnt !== 32'(base + 1)) begin
         errors++; $display("FAIL load_use_stall: got %0d expected %0d", stall_cnt, base + 1);
      end
      next_cycle();
      ex_mem_read = 1'b1; ex_rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
      #1;
      checks++;
      if (obs !== P_IDLE) begin errors++; $display("FAIL load_use_rd0: got %b expected %b", obs, P_IDLE); end
      next_cycle();
      ex_rd = 5'd7; rs1 = 5'd3; rs1_used = 1'b1; rs2 = 5'd7; rs2_used = 1'b0;
      #1;
      checks++;
      if (obs !== P_IDLE) begin errors++; $display("FAIL load_use_rs2_unused: got %b expected %b", obs, P_IDLE); end
      next_cycle();
      rs2_used = 1'b1;
      #1;
      checks++;
      if (obs !== P_LU) begin errors++; $display("FAIL load_use_rs2: got %b expected %b", obs, P_LU); end
      next_cycle();
      set_idle();
   endtask

   task automatic test_redirect();
      longint base;
      base = m_stall;
      set_idle();
      redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; rs1 = 5'd9; rs1_used = 1'b1;
      #1;
      checks++;
      if (obs !== P_REDIR) begin errors++; $display("FAIL redirect_beats_lu: got %b expected %b", obs, P_REDIR); end
      next_cycle();
      set_idle();
      #1;
      checks++;
      if (stall_cnt !== 32'(base)) begin
         errors++; $display("FAIL redirect_no_stall: got %0d expected %0d", stall_cnt, base);
      end
   endtask

   task automatic test_divide();
      longint base;
      base = m_stall;
      set_idle();
      ex_div = 1'b1;
      #1;
      checks++;
      if (obs !== P_START) begin errors++; $display("FAIL div_start: got %b expected %b", obs, P_START); end
      checks++;
      if (s_div_start !== 1'b1 || s_div_done !== 1'b0) begin
         errors++; $display("FAIL minlat_start: got start=%b done=%b expected 1/0", s_div_start, s_div_done);
      end
      next_cycle();
      checks++;
      if (s_div_start !== 1'b0 || s_div_done !== 1'b1) begin
         errors++; $display("FAIL minlat_done: got start=%b done=%b expected 0/1", s_div_start, s_div_done);
      end
      for (int k = 1; k <= L - 2; k++) begin
         checks++;
         if (obs !== P_BUSY) begin errors++; $display("FAIL div_busy k=%0d: got %b expected %b", k, obs, P_BUSY); end
         next_cycle();
      end
      checks++;
      if (obs !== P_DONE) begin errors++; $display("FAIL div_done: got %b expected %b", obs, P_DONE); end
      next_cycle();
      ex_div = 1'b0;
      #1;
      checks++;
      if (obs !== P_IDLE) begin errors++; $display("FAIL div_after: got %b expected %b", obs, P_IDLE); end
      checks++;
      if (stall_cnt !== 32'(base + L - 1)) begin
         errors++; $display("FAIL div_stall: got %0d expected %0d", stall_cnt, base + L - 1);
      end
   endtask

   task automatic test_div_freeze();
      set_idle();
      ex_div = 1'b1;
      #1;
      checks++;
      if (obs !== P_START) begin errors++; $display("FAIL dfz_start: got %b expected %b", obs, P_START); end
      next_cycle();
      for (int k = 1; k <= L - 3; k++) next_cycle();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      checks++;
      if (obs !== P_FRZ) begin errors++; $display("FAIL dfz_busy_frozen: got %b expected %b", obs, P_FRZ); end
      next_cycle();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs !== P_FRZ_DONE) begin errors++; $display("FAIL dfz_done_frozen %0d: got %b expected %b", k, obs, P_FRZ_DONE); end
         next_cycle();
      end
      mem_req = 1'b0;
      #1;
      checks++;
      if (obs !== P_DONE) begin errors++; $display("FAIL dfz_done_release: got %b expected %b", obs, P_DONE); end
      next_cycle();
      ex_div = 1'b0;
      #1;
      checks++;
      if (obs !== P_IDLE) begin errors++; $display("FAIL dfz_after: got %b expected %b", obs, P_IDLE); end
   endtask

   task automatic test_reset_mid_div();
      set_idle();
      ex_div = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) next_cycle();
      set_idle();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs !== P_IDLE || stall_cnt !== 32'd0) begin
         errors++; $display("FAIL async_reset: got %b/%0d expected %b/0", obs, stall_cnt, P_IDLE);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < L + 4; k++) begin
         #1;
         checks++;
         if (obs !== P_IDLE || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_no_done k=%0d: got %b/%0d expected %b/0", k, obs, stall_cnt, P_IDLE);
         end
         next_cycle();
      end
   endtask

   task automatic test_saturation();
      set_idle();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         next_cycle();
         checks++;
         if (s_stall_cnt !== 4'((n < 15) ? n : 15)) begin
            errors++; $display("FAIL stall_saturate n=%0d: got %0d expected %0d", n, s_stall_cnt, (n < 15) ? n : 15);
         end
      end
      set_idle();
      next_cycle();
   endtask

   task automatic test_random();
      logic [9:0] e;
      for (int c = 0; c < 3000; c++) begin
         rs1         = 5'($urandom_range(0, 3));
         rs2         = 5'($urandom_range(0, 3));
         ex_rd       = 5'($urandom_range(0, 3));
         rs1_used    = ($urandom_range(0, 1) == 1);
         rs2_used    = ($urandom_range(0, 1) == 1);
         ex_mem_read = ($urandom_range(0, 2) == 0);
         ex_div      = ($urandom_range(0, 19) == 0);
         redirect    = ($urandom_range(0, 5) == 0);
         mem_req     = ($urandom_range(0, 2) == 0);
         mem_ready   = ($urandom_range(0, 1) == 1);
         #1;
         e = model_out();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL random_outputs cyc=%0d: got %b expected %b", c, obs, e); end
         checks++;
         if (stall_cnt !== 32'(m_stall)) begin
            errors++; $display("FAIL random_stall cyc=%0d: got %0d expected %0d", c, stall_cnt, m_stall);
         end
         next_cycle();
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_divide();
      test_div_freeze();
      test_reset_mid_div();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
